// File: rtl/controller_cmd_queue_if.sv
// Command-queue port bundle between the io/controller side and the queue.
// The master side issues key codes and handshakes; the slave side is the queue itself.
interface controller_cmd_queue_if #(
  parameter int CMD_W = 5,
  parameter int CNT_W = 3
);

  logic [CMD_W-1:0] in_cmd;
  logic             in_valid;
  logic             accept_en;
  logic             cmd_pop;
  logic             flush;
  logic             clear_ovf;

  logic [CMD_W-1:0] cmd_head;
  logic             cmd_valid;
  logic [CMD_W-1:0] cmd_last;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             overflow;

  modport master (
    output in_cmd, in_valid, accept_en, cmd_pop, flush, clear_ovf,
    input  cmd_head, cmd_valid, cmd_last, count, full, overflow
  );

  modport slave (
    input  in_cmd, in_valid, accept_en, cmd_pop, flush, clear_ovf,
    output cmd_head, cmd_valid, cmd_last, count, full, overflow
  );

endinterface

// File: rtl/controller_cmd_queue.sv
// In-order command buffer between the io key strobe and the calculator controller FSM.
// Keeps key presses that arrive while the controller is busy and hands them out oldest-first.
module controller_cmd_queue #(
  parameter int               CMD_W    = 5,
  parameter int               DEPTH    = 4,
  parameter logic [CMD_W-1:0] CMD_IDLE = '0,
  parameter bit               DROP_NEW = 1'b1,
  parameter int               CNT_W    = 3
) (
  input logic                   Clock,
  input logic                   Reset,
  controller_cmd_queue_if.slave bus
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [CMD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;
  logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic [CNT_W-1:0] count_q, count_nxt;
  logic             overflow_q, overflow_nxt;
  logic [CMD_W-1:0] last_q, last_nxt;
  logic             push, pop, is_empty, is_full, mem_we;

  // DEPTH need not be a power of two, so wrap explicitly at the last slot.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_FULL);
  assign push     = bus.in_valid & bus.accept_en;
  assign pop      = bus.cmd_pop & ~is_empty;

  always_comb begin
    rd_ptr_nxt   = rd_ptr;
    wr_ptr_nxt   = wr_ptr;
    count_nxt    = count_q;
    overflow_nxt = overflow_q;
    last_nxt     = last_q;
    mem_we       = 1'b0;

    if (bus.flush) begin
      rd_ptr_nxt   = '0;
      wr_ptr_nxt   = '0;
      count_nxt    = '0;
      overflow_nxt = 1'b0;
    end else begin
      if (push && (!is_full || pop)) begin
        mem_we     = 1'b1;
        wr_ptr_nxt = ptr_inc(wr_ptr);
        last_nxt   = bus.in_cmd;
        if (pop)
          rd_ptr_nxt = ptr_inc(rd_ptr);
        else
          count_nxt = count_q + CNT_W'(1);
      end else if (push) begin
        // Overwrite mode sacrifices the oldest entry so the newest key survives.
        if (!DROP_NEW) begin
          mem_we     = 1'b1;
          wr_ptr_nxt = ptr_inc(wr_ptr);
          rd_ptr_nxt = ptr_inc(rd_ptr);
          last_nxt   = bus.in_cmd;
        end
      end else if (pop) begin
        rd_ptr_nxt = ptr_inc(rd_ptr);
        count_nxt  = count_q - CNT_W'(1);
      end

      if (push && is_full && !pop)
        overflow_nxt = 1'b1;
      else if (bus.clear_ovf)
        overflow_nxt = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      last_q     <= CMD_IDLE;
    end else begin
      rd_ptr     <= rd_ptr_nxt;
      wr_ptr     <= wr_ptr_nxt;
      count_q    <= count_nxt;
      overflow_q <= overflow_nxt;
      last_q     <= last_nxt;
    end
  end

  // Storage carries no reset; only entries between the pointers are ever observed.
  always_ff @(posedge Clock) begin
    if (mem_we)
      mem[wr_ptr] <= bus.in_cmd;
  end

  assign bus.cmd_head  = is_empty ? CMD_IDLE : mem[rd_ptr];
  assign bus.cmd_valid = ~is_empty;
  assign bus.cmd_last  = last_q;
  assign bus.count     = count_q;
  assign bus.full      = is_full;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_controller_cmd_queue.sv
// Directed bench for controller_cmd_queue: drop-new and overwrite variants at DEPTH=4,
// plus a DEPTH=3 instance for non-power-of-two pointer wrap.
module tb_controller_cmd_queue;

  typedef struct packed {
    logic [4:0] cmd;
    logic       vld;
    logic       acc;
    logic       pop;
    logic       fl;
    logic       clr;
    logic [4:0] eHead;
    logic       eValid;
    logic [4:0] eLast;
    logic [2:0] eCount;
    logic       eFull;
    logic       eOvf;
  } vec_t;

  logic       clock;
  logic       rstN;
  logic [4:0] inCmd;
  logic       inValid, acceptEn, cmdPop, flushIn, clearOvf;
  int         sel;

  logic [4:0] obsHead, obsLast;
  logic       obsValid, obsFull, obsOvf;
  logic [2:0] obsCount;

  int compared   = 0;
  int mismatched = 0;

  vec_t       vecs [25];
  logic [4:0] model [$];

  controller_cmd_queue_if #(.CMD_W(5), .CNT_W(3)) busA ();
  controller_cmd_queue_if #(.CMD_W(5), .CNT_W(3)) busB ();
  controller_cmd_queue_if #(.CMD_W(5), .CNT_W(3)) busC ();

  controller_cmd_queue #(.CMD_W(5), .DEPTH(4), .CMD_IDLE(5'h00), .DROP_NEW(1'b1), .CNT_W(3))
    dutA (.Clock(clock), .Reset(rstN), .bus(busA));
  controller_cmd_queue #(.CMD_W(5), .DEPTH(4), .CMD_IDLE(5'h00), .DROP_NEW(1'b0), .CNT_W(3))
    dutB (.Clock(clock), .Reset(rstN), .bus(busB));
  controller_cmd_queue #(.CMD_W(5), .DEPTH(3), .CMD_IDLE(5'h00), .DROP_NEW(1'b1), .CNT_W(3))
    dutC (.Clock(clock), .Reset(rstN), .bus(busC));

  // Only the selected instance sees strobes; the others hold their state.
  assign busA.in_cmd    = inCmd;
  assign busA.in_valid  = inValid && (sel == 0);
  assign busA.accept_en = acceptEn;
  assign busA.cmd_pop   = cmdPop && (sel == 0);
  assign busA.flush     = flushIn && (sel == 0);
  assign busA.clear_ovf = clearOvf && (sel == 0);

  assign busB.in_cmd    = inCmd;
  assign busB.in_valid  = inValid && (sel == 1);
  assign busB.accept_en = acceptEn;
  assign busB.cmd_pop   = cmdPop && (sel == 1);
  assign busB.flush     = flushIn && (sel == 1);
  assign busB.clear_ovf = clearOvf && (sel == 1);

  assign busC.in_cmd    = inCmd;
  assign busC.in_valid  = inValid && (sel == 2);
  assign busC.accept_en = acceptEn;
  assign busC.cmd_pop   = cmdPop && (sel == 2);
  assign busC.flush     = flushIn && (sel == 2);
  assign busC.clear_ovf = clearOvf && (sel == 2);

  // Route the selected instance's outputs to one set of observation signals.
  always_comb begin
    obsHead  = busA.cmd_head;
    obsValid = busA.cmd_valid;
    obsLast  = busA.cmd_last;
    obsCount = busA.count;
    obsFull  = busA.full;
    obsOvf   = busA.overflow;
    if (sel == 1) begin
      obsHead  = busB.cmd_head;
      obsValid = busB.cmd_valid;
      obsLast  = busB.cmd_last;
      obsCount = busB.count;
      obsFull  = busB.full;
      obsOvf   = busB.overflow;
    end else if (sel == 2) begin
      obsHead  = busC.cmd_head;
      obsValid = busC.cmd_valid;
      obsLast  = busC.cmd_last;
      obsCount = busC.count;
      obsFull  = busC.full;
      obsOvf   = busC.overflow;
    end
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, let the edge happen, return to idle 1 time unit after it.
  task automatic applyStimulus(input logic [4:0] cmd, input logic vld, input logic acc,
                               input logic pop, input logic fl, input logic clr);
    inCmd    = cmd;
    inValid  = vld;
    acceptEn = acc;
    cmdPop   = pop;
    flushIn  = fl;
    clearOvf = clr;
    @(posedge clock);
    #1;
    inValid  = 1'b0;
    cmdPop   = 1'b0;
    flushIn  = 1'b0;
    clearOvf = 1'b0;
  endtask

  initial begin
    sel      = 0;
    inCmd    = '0;
    inValid  = 1'b0;
    acceptEn = 1'b1;
    cmdPop   = 1'b0;
    flushIn  = 1'b0;
    clearOvf = 1'b0;

    //            cmd   v  a  p  f  c   head  V  last  cnt F  O
    vecs[0]  = '{5'h03,1'b1,1'b1,1'b0,1'b0,1'b0, 5'h03,1'b1,5'h03,3'd1,1'b0,1'b0};
    vecs[1]  = '{5'h07,1'b1,1'b1,1'b0,1'b0,1'b0, 5'h03,1'b1,5'h07,3'd2,1'b0,1'b0};
    vecs[2]  = '{5'h0A,1'b1,1'b1,1'b0,1'b0,1'b0, 5'h03,1'b1,5'h0A,3'd3,1'b0,1'b0};
    vecs[3]  = '{5'h00,1'b0,1'b1,1'b1,1'b0,1'b0, 5'h07,1'b1,5'h0A,3'd2,1'b0,1'b0};
    vecs[4]  = '{5'h00,1'b0,1'b1,1'b1,1'b0,1'b0, 5'h0A,1'b1,5'h0A,3'd1,1'b0,1'b0};
    vecs[5]  = '{5'h00,1'b0,1'b1,1'b1,1'b0,1'b0, 5'h00,1'b0,5'h0A,3'd0,1'b0,1'b0};
    vecs[6]  = '{5'h11,1'b1,1'b0,1'b0,1'b0,1'b0, 5'h00,1'b0,5'h0A,3'd0,1'b0,1'b0};
    vecs[7]  = '{5'h00,1'b0,1'b1,1'b1,1'b0,1'b0, 5'h00,1'b0,5'h0A,3'd0,1'b0,1'b0};
    vecs[8]  = '{5'h01,1'b1,1'b1,1'b0,1'b0,1'b0, 5'h01,1'b1,5'h01,3'd1,1'b0,1'b0};
    vecs[9]  = '{5'h02,1'b1,1'b1,1'b0,1'b0,1'b0, 5'h01,1'b1,5'h02,3'd2,1'b0,1'b0};
    vecs[10] = '{5'h03,1'b1,1'b1,1'b0,1'b0,1'b0, 5'h01,1'b1,5'h03,3'd3,1'b0,1'b0};
    vecs[11] = '{5'h04,1'b1,1'b1,1'b0,1'b0,1'b0, 5'h01,1'b1,5'h04,3'd4,1'b1,1'b0};
    vecs[12] = '{5'h05,1'b1,1'b1,1'b0,1'b0,1'b0, 5'h01,1'b1,5'h04,3'd4,1'b1,1'b1};
    vecs[13] = '{5'h00,1'b0,1'b1,1'b0,1'b0,1'b1, 5'h01,1'b1,5'h04,3'd4,1'b1,1'b0};
    vecs[14] = '{5'h1F,1'b1,1'b1,1'b1,1'b0,1'b0, 5'h02,1'b1,5'h1F,3'd4,1'b1,1'b0};
    vecs[15] = '{5'h06,1'b1,1'b1,1'b0,1'b0,1'b1, 5'h02,1'b1,5'h1F,3'd4,1'b1,1'b1};
    vecs[16] = '{5'h00,1'b0,1'b1,1'b1,1'b0,1'b0, 5'h03,1'b1,5'h1F,3'd3,1'b0,1'b1};
    vecs[17] = '{5'h00,1'b0,1'b1,1'b1,1'b0,1'b0, 5'h04,1'b1,5'h1F,3'd2,1'b0,1'b1};
    vecs[18] = '{5'h00,1'b0,1'b1,1'b1,1'b0,1'b0, 5'h1F,1'b1,5'h1F,3'd1,1'b0,1'b1};
    vecs[19] = '{5'h00,1'b0,1'b1,1'b1,1'b0,1'b0, 5'h00,1'b0,5'h1F,3'd0,1'b0,1'b1};
    vecs[20] = '{5'h08,1'b1,1'b1,1'b0,1'b0,1'b0, 5'h08,1'b1,5'h08,3'd1,1'b0,1'b1};
    vecs[21] = '{5'h0B,1'b1,1'b1,1'b0,1'b0,1'b0, 5'h08,1'b1,5'h0B,3'd2,1'b0,1'b1};
    vecs[22] = '{5'h09,1'b1,1'b1,1'b0,1'b1,1'b0, 5'h00,1'b0,5'h0B,3'd0,1'b0,1'b0};
    vecs[23] = '{5'h0C,1'b1,1'b1,1'b1,1'b0,1'b0, 5'h0C,1'b1,5'h0C,3'd1,1'b0,1'b0};
    vecs[24] = '{5'h00,1'b0,1'b1,1'b1,1'b0,1'b0, 5'h00,1'b0,5'h0C,3'd0,1'b0,1'b0};

    rstN = 1'b1;
    #1 rstN = 1'b0;
    #2;
    checkOutput("reset.head",  32'(obsHead),  32'h00);
    checkOutput("reset.valid", 32'(obsValid), 32'h0);
    checkOutput("reset.last",  32'(obsLast),  32'h00);
    checkOutput("reset.count", 32'(obsCount), 32'h0);
    checkOutput("reset.full",  32'(obsFull),  32'h0);
    checkOutput("reset.ovf",   32'(obsOvf),   32'h0);
    #5 rstN = 1'b1;

    for (int i = 0; i < 25; i++) begin
      applyStimulus(vecs[i].cmd, vecs[i].vld, vecs[i].acc, vecs[i].pop, vecs[i].fl, vecs[i].clr);
      checkOutput($sformatf("v%0d.head", i),  32'(obsHead),  32'(vecs[i].eHead));
      checkOutput($sformatf("v%0d.valid", i), 32'(obsValid), 32'(vecs[i].eValid));
      checkOutput($sformatf("v%0d.last", i),  32'(obsLast),  32'(vecs[i].eLast));
      checkOutput($sformatf("v%0d.count", i), 32'(obsCount), 32'(vecs[i].eCount));
      checkOutput($sformatf("v%0d.full", i),  32'(obsFull),  32'(vecs[i].eFull));
      checkOutput($sformatf("v%0d.ovf", i),   32'(obsOvf),   32'(vecs[i].eOvf));
    end

    // Async reset mid-run with three entries and overflow set.
    for (int k = 0; k < 5; k++)
      applyStimulus(5'(5'h0D + k), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(5'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("prerst.count", 32'(obsCount), 32'd3);
    checkOutput("prerst.ovf",   32'(obsOvf),   32'h1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("midrst.count", 32'(obsCount), 32'd0);
    checkOutput("midrst.valid", 32'(obsValid), 32'h0);
    checkOutput("midrst.head",  32'(obsHead),  32'h00);
    checkOutput("midrst.ovf",   32'(obsOvf),   32'h0);
    checkOutput("midrst.last",  32'(obsLast),  32'h00);
    #2 rstN = 1'b1;

    // Overwrite-oldest variant: push 1..5 into DEPTH=4, expect 2,3,4,5 out.
    sel = 1;
    for (int k = 1; k <= 5; k++)
      applyStimulus(5'(k), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("ovw.full",  32'(obsFull),  32'h1);
    checkOutput("ovw.ovf",   32'(obsOvf),   32'h1);
    checkOutput("ovw.last",  32'(obsLast),  32'h05);
    checkOutput("ovw.count", 32'(obsCount), 32'd4);
    for (int k = 2; k <= 5; k++) begin
      checkOutput($sformatf("ovw.pop%0d", k), 32'(obsHead), 32'(k));
      applyStimulus(5'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    checkOutput("ovw.empty", 32'(obsValid), 32'h0);

    // DEPTH=3: steady push+pop at count 2 walks both pointers through the wrap.
    sel = 2;
    model.delete();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(5'(5'h10 + k), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      model.push_back(5'(5'h10 + k));
    end
    checkOutput("wrap.count0", 32'(obsCount), 32'd2);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(5'(5'h12 + k), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      model.push_back(5'(5'h12 + k));
      void'(model.pop_front());
      checkOutput($sformatf("wrap.head%0d", k),  32'(obsHead),  32'(model[0]));
      checkOutput($sformatf("wrap.count%0d", k), 32'(obsCount), 32'd2);
    end
    applyStimulus(5'h1E, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    model.push_back(5'h1E);
    checkOutput("wrap.full",  32'(obsFull),  32'h1);
    checkOutput("wrap.count", 32'(obsCount), 32'd3);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("wrap.drain%0d", k), 32'(obsHead), 32'(model[0]));
      void'(model.pop_front());
      applyStimulus(5'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    checkOutput("wrap.empty", 32'(obsValid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
